// File: rtl/fp8_pkg.sv
// Shared widths and feeder FSM encoding for the FP8 array front end.
package fp8_pkg;
    localparam int FP8_W  = 8;
    localparam int LANES  = 2;
    localparam int C_W    = 32;
    localparam int VEC_W  = FP8_W * LANES;
    localparam int PAIR_W = 2 * VEC_W;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FEED,
        WAIT,
        READ,
        OUT
    } feeder_state_t;
endpackage

// File: rtl/fp8_operand_fifo.sv
// Operand-pair FIFO with registered full/empty flags and zeroed head when empty.
module fp8_operand_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [AW:0]   count_next;
    logic          do_push;
    logic          do_pop;

    // Full is a registered flag, so a pop never frees a slot in the same cycle.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        count_next = count;
        unique case ({do_push, do_pop})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count_next;
            full  <= (count_next == FULL_CNT);
            empty <= (count_next == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    assign head = empty ? '0 : mem[rd_ptr];
endmodule

// File: rtl/fp8_array_feeder.sv
// Tile sequencer: clears the array, streams K operand pairs, reads back the 2x2 result.
module fp8_array_feeder
    import fp8_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int K_W        = 8
) (
    input  logic             clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic [K_W-1:0]   i_k_len,
    input  logic [VEC_W-1:0] i_s_a_vector,
    input  logic [VEC_W-1:0] i_s_b_vector,
    input  logic             i_s_valid,
    output logic             o_s_ready,
    output logic [VEC_W-1:0] o_a_vector,
    output logic [VEC_W-1:0] o_b_vector,
    output logic             o_data_valid,
    output logic             o_read_en,
    output logic             o_clear_acc,
    input  logic             i_mac_done,
    input  logic             i_ready_for_new,
    input  logic [C_W-1:0]   i_c_matrix,
    output logic [C_W-1:0]   o_result,
    output logic             o_result_valid,
    input  logic             i_result_ready,
    output logic             o_busy,
    output logic             o_tile_done
);
    feeder_state_t state;
    feeder_state_t state_next;

    logic [K_W:0]      k_reg;
    logic [K_W:0]      beat_cnt;
    logic [K_W:0]      beat_inc;
    logic [PAIR_W-1:0] head;
    logic              full;
    logic              empty;
    logic              beat;
    logic              last_beat;

    assign o_s_ready  = !full;
    assign o_a_vector = head[VEC_W-1:0];
    assign o_b_vector = head[PAIR_W-1:VEC_W];
    assign o_busy     = (state != IDLE);
    assign beat       = o_data_valid && i_ready_for_new;
    assign beat_inc   = beat_cnt + 1'b1;
    assign last_beat  = beat && (beat_inc == k_reg);

    fp8_operand_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (PAIR_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (i_reset),
        .push  (i_s_valid),
        .din   ({i_s_b_vector, i_s_a_vector}),
        .pop   (beat),
        .head  (head),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk) begin
        if (i_reset) state <= IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (i_start) state_next = CLEAR;
            CLEAR:   state_next = FEED;
            FEED:    if (last_beat) state_next = WAIT;
            WAIT:    if (i_mac_done && i_ready_for_new) state_next = READ;
            READ:    state_next = OUT;
            OUT:     if (i_result_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        o_data_valid   = 1'b0;
        o_clear_acc    = 1'b0;
        o_read_en      = 1'b0;
        o_result_valid = 1'b0;
        o_tile_done    = 1'b0;
        unique case (state)
            CLEAR: o_clear_acc = 1'b1;
            FEED:  o_data_valid = !empty;
            READ:  o_read_en = 1'b1;
            OUT: begin
                o_result_valid = 1'b1;
                o_tile_done    = i_result_ready;
            end
            default: ;
        endcase
    end

    // A zero length field means the full 2^K_W beats, held in the extra count bit.
    always_ff @(posedge clk) begin
        if (i_reset) begin
            k_reg    <= '0;
            beat_cnt <= '0;
            o_result <= '0;
        end else begin
            if (state == IDLE && i_start) k_reg <= {~|i_k_len, i_k_len};
            if (state == CLEAR)  beat_cnt <= '0;
            else if (beat)       beat_cnt <= beat_inc;
            if (state == READ)   o_result <= i_c_matrix;
        end
    end
endmodule

// File: tb/tb_fp8_array_feeder.sv
// Scoreboard bench for fp8_array_feeder with a small behavioural array model.
module tb_fp8_array_feeder;
    logic        clk = 1'b0;
    logic        i_reset;
    logic        i_start;
    logic [7:0]  i_k_len;
    logic [15:0] i_s_a_vector;
    logic [15:0] i_s_b_vector;
    logic        i_s_valid;
    logic        o_s_ready;
    logic [15:0] o_a_vector;
    logic [15:0] o_b_vector;
    logic        o_data_valid;
    logic        o_read_en;
    logic        o_clear_acc;
    logic        i_mac_done;
    logic        i_ready_for_new;
    logic [31:0] i_c_matrix;
    logic [31:0] o_result;
    logic        o_result_valid;
    logic        i_result_ready;
    logic        o_busy;
    logic        o_tile_done;

    always #5 clk = ~clk;

    fp8_array_feeder #(.FIFO_DEPTH(4), .K_W(8)) dut (
        .clk             (clk),
        .i_reset         (i_reset),
        .i_start         (i_start),
        .i_k_len         (i_k_len),
        .i_s_a_vector    (i_s_a_vector),
        .i_s_b_vector    (i_s_b_vector),
        .i_s_valid       (i_s_valid),
        .o_s_ready       (o_s_ready),
        .o_a_vector      (o_a_vector),
        .o_b_vector      (o_b_vector),
        .o_data_valid    (o_data_valid),
        .o_read_en       (o_read_en),
        .o_clear_acc     (o_clear_acc),
        .i_mac_done      (i_mac_done),
        .i_ready_for_new (i_ready_for_new),
        .i_c_matrix      (i_c_matrix),
        .o_result        (o_result),
        .o_result_valid  (o_result_valid),
        .i_result_ready  (i_result_ready),
        .o_busy          (o_busy),
        .o_tile_done     (o_tile_done)
    );

    int n_vec = 0;
    int n_bad = 0;
    int cyc = 0;

    logic [31:0] src_q[$];
    logic [31:0] exp_q[$];
    logic [31:0] got_q[$];

    int  tile_k = 0;
    int  tile_beats = 0;
    logic [31:0] cur_c = '0;
    bit  rdy_alt = 1'b0;
    bit  poke_start = 1'b0;
    bit  last_rv_wait = 1'b0;
    int  ready_delay = 0;
    int  rv_cnt = 0;
    int  rv_high = 0;
    int  n_clear = 0;
    int  n_read = 0;
    int  n_done = 0;
    int  start_cyc = 0;
    int  clear_cyc = 0;
    int  first_beat_cyc = 0;
    int  last_beat_cyc = 0;
    int  mac_cyc = -1;
    int  read_cyc = 0;
    int  rv_cyc = 0;
    int  res_changed = 0;
    int  hold_breaks = 0;
    logic [31:0] res_got = '0;
    logic [31:0] res_first = '0;
    logic [31:0] held = '0;
    bit  held_valid = 1'b0;

    // One clock: drive after the edge, observe at the falling edge.
    task automatic tick();
        logic [31:0] d;
        i_s_valid = (src_q.size() != 0);
        if (i_s_valid) {i_s_b_vector, i_s_a_vector} = src_q[0];
        else           {i_s_b_vector, i_s_a_vector} = '0;
        i_ready_for_new = rdy_alt ? cyc[0] : 1'b1;
        i_mac_done      = (tile_k != 0) && (tile_beats == tile_k);
        i_c_matrix      = i_mac_done ? cur_c : ~cur_c;
        i_result_ready  = (rv_cnt >= ready_delay);
        if (poke_start) i_start = last_rv_wait;
        @(negedge clk);
        d = {o_b_vector, o_a_vector};
        if (i_s_valid && o_s_ready) exp_q.push_back(src_q.pop_front());
        if (held_valid && (!o_data_valid || d !== held)) hold_breaks++;
        held_valid = o_data_valid && !i_ready_for_new;
        held = d;
        if (o_data_valid && i_ready_for_new) begin
            got_q.push_back(d);
            if (tile_beats == 0) first_beat_cyc = cyc;
            last_beat_cyc = cyc;
            tile_beats++;
        end
        if (o_clear_acc) begin
            n_clear++;
            clear_cyc = cyc;
            tile_beats = 0;
        end
        if (i_mac_done && mac_cyc < 0) mac_cyc = cyc;
        if (o_read_en) begin
            n_read++;
            read_cyc = cyc;
        end
        if (o_result_valid) begin
            if (rv_cnt == 0) begin
                rv_cyc = cyc;
                res_first = o_result;
            end else if (o_result !== res_first) begin
                res_changed++;
            end
            rv_cnt++;
        end
        last_rv_wait = o_result_valid && !i_result_ready;
        if (o_result_valid && i_result_ready) begin
            res_got = o_result;
            rv_high = rv_cnt;
            rv_cnt = 0;
        end
        if (o_tile_done) n_done++;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_tile(input logic [7:0] kl, input int k, input int budget,
                            input bit poke, output bit timed_out);
        int g;
        g = 0;
        tile_k = k;
        tile_beats = 0;
        mac_cyc = -1;
        n_clear = 0;
        n_read = 0;
        n_done = 0;
        res_changed = 0;
        cur_c = $urandom;
        i_k_len = kl;
        i_start = 1'b1;
        start_cyc = cyc;
        tick();
        i_start = 1'b0;
        i_k_len = ~kl;
        poke_start = poke;
        while (n_done == 0 && g < budget) begin
            tick();
            g++;
        end
        poke_start = 1'b0;
        i_start = 1'b0;
        tile_k = 0;
        timed_out = (n_done == 0);
    endtask

    task automatic test_reset();
        i_reset = 1'b1;
        tick();
        tick();
        i_reset = 1'b0;
        n_vec++;
        if ({o_s_ready, o_data_valid, o_read_en, o_clear_acc, o_result_valid, o_busy, o_tile_done} !== 7'b1000000) begin
            n_bad++;
            $display("FAIL reset_flags got %b want 1000000",
                {o_s_ready, o_data_valid, o_read_en, o_clear_acc, o_result_valid, o_busy, o_tile_done});
        end
        n_vec++;
        if (o_result !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_result got %h want 0", o_result);
        end
        n_vec++;
        if ({o_b_vector, o_a_vector} !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_head got %h want 0", {o_b_vector, o_a_vector});
        end
    endtask

    task automatic test_basic();
        bit to;
        logic [31:0] g, w;
        for (int i = 0; i < 3; i++) src_q.push_back(32'h4040_3838);
        repeat (4) tick();
        run_tile(8'd3, 3, 40, 1'b0, to);
        n_vec++;
        if (to) begin n_bad++; $display("FAIL basic_timeout got 1 want 0"); end
        n_vec++;
        if (tile_beats !== 3) begin n_bad++; $display("FAIL basic_beats got %0d want 3", tile_beats); end
        n_vec++;
        if (n_clear !== 1 || clear_cyc !== start_cyc + 1) begin
            n_bad++;
            $display("FAIL basic_clear got n=%0d at %0d want 1 at %0d", n_clear, clear_cyc, start_cyc + 1);
        end
        n_vec++;
        if (first_beat_cyc !== start_cyc + 2) begin
            n_bad++;
            $display("FAIL basic_first_beat got %0d want %0d", first_beat_cyc, start_cyc + 2);
        end
        n_vec++;
        if (n_read !== 1 || mac_cyc < 0 || read_cyc <= mac_cyc) begin
            n_bad++;
            $display("FAIL basic_read got n=%0d at %0d want 1 after %0d", n_read, read_cyc, mac_cyc);
        end
        n_vec++;
        if (rv_cyc !== last_beat_cyc + 3) begin
            n_bad++;
            $display("FAIL basic_latency got %0d want %0d", rv_cyc, last_beat_cyc + 3);
        end
        n_vec++;
        if (res_got !== cur_c) begin n_bad++; $display("FAIL basic_result got %h want %h", res_got, cur_c); end
        while (got_q.size() != 0 || exp_q.size() != 0) begin
            g = (got_q.size() != 0) ? got_q.pop_front() : 'x;
            w = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
            n_vec++;
            if (g !== w) begin n_bad++; $display("FAIL basic_beat got %h want %h", g, w); end
        end
    endtask

    task automatic test_backpressure();
        bit to;
        logic [31:0] g, w;
        for (int i = 0; i < 4; i++) src_q.push_back(32'h4000_3800 + 32'(i * 32'h0101_0101));
        rdy_alt = 1'b1;
        hold_breaks = 0;
        run_tile(8'd4, 4, 60, 1'b0, to);
        rdy_alt = 1'b0;
        n_vec++;
        if (to) begin n_bad++; $display("FAIL bp_timeout got 1 want 0"); end
        n_vec++;
        if (tile_beats !== 4) begin n_bad++; $display("FAIL bp_beats got %0d want 4", tile_beats); end
        n_vec++;
        if (hold_breaks !== 0) begin n_bad++; $display("FAIL bp_hold got %0d want 0", hold_breaks); end
        n_vec++;
        if (res_got !== cur_c) begin n_bad++; $display("FAIL bp_result got %h want %h", res_got, cur_c); end
        while (got_q.size() != 0 || exp_q.size() != 0) begin
            g = (got_q.size() != 0) ? got_q.pop_front() : 'x;
            w = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
            n_vec++;
            if (g !== w) begin n_bad++; $display("FAIL bp_beat got %h want %h", g, w); end
        end
    endtask

    task automatic test_fifo_full();
        bit to;
        logic [31:0] g, w;
        for (int i = 0; i < 6; i++) src_q.push_back(32'hA000_0000 + 32'(i));
        repeat (8) tick();
        n_vec++;
        if (exp_q.size() !== 4 || src_q.size() !== 2) begin
            n_bad++;
            $display("FAIL full_accepted got %0d want 4", exp_q.size());
        end
        n_vec++;
        if (o_s_ready !== 1'b0) begin n_bad++; $display("FAIL full_ready got %b want 0", o_s_ready); end
        run_tile(8'd6, 6, 60, 1'b0, to);
        n_vec++;
        if (to || src_q.size() !== 0) begin
            n_bad++;
            $display("FAIL full_drain got left=%0d to=%0d want 0", src_q.size(), to);
        end
        while (got_q.size() != 0 || exp_q.size() != 0) begin
            g = (got_q.size() != 0) ? got_q.pop_front() : 'x;
            w = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
            n_vec++;
            if (g !== w) begin n_bad++; $display("FAIL full_beat got %h want %h", g, w); end
        end
    endtask

    task automatic test_k_zero();
        bit to;
        logic [31:0] g, w;
        for (int i = 0; i < 256; i++) src_q.push_back($urandom);
        run_tile(8'd0, 256, 3000, 1'b0, to);
        n_vec++;
        if (to) begin n_bad++; $display("FAIL k0_timeout got 1 want 0"); end
        n_vec++;
        if (tile_beats !== 256 || read_cyc <= last_beat_cyc) begin
            n_bad++;
            $display("FAIL k0_beats got %0d want 256", tile_beats);
        end
        n_vec++;
        if (res_got !== cur_c) begin n_bad++; $display("FAIL k0_result got %h want %h", res_got, cur_c); end
        while (got_q.size() != 0 || exp_q.size() != 0) begin
            g = (got_q.size() != 0) ? got_q.pop_front() : 'x;
            w = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
            n_vec++;
            if (g !== w) begin n_bad++; $display("FAIL k0_beat got %h want %h", g, w); end
        end
    endtask

    task automatic test_result_hold();
        bit to;
        logic [31:0] g, w;
        src_q.push_back(32'h1234_5678);
        src_q.push_back(32'h9ABC_DEF0);
        ready_delay = 5;
        run_tile(8'd2, 2, 60, 1'b1, to);
        ready_delay = 0;
        n_vec++;
        if (to || n_done !== 1) begin n_bad++; $display("FAIL hold_done got %0d want 1", n_done); end
        n_vec++;
        if (rv_high !== 6) begin n_bad++; $display("FAIL hold_valid_len got %0d want 6", rv_high); end
        n_vec++;
        if (res_changed !== 0) begin n_bad++; $display("FAIL hold_stable got %0d want 0", res_changed); end
        n_vec++;
        if (res_got !== cur_c) begin n_bad++; $display("FAIL hold_result got %h want %h", res_got, cur_c); end
        tick();
        n_vec++;
        if (n_clear !== 1 || o_busy !== 1'b0 || o_clear_acc !== 1'b0) begin
            n_bad++;
            $display("FAIL hold_start_ignored got clears=%0d busy=%b want 1 0", n_clear, o_busy);
        end
        while (got_q.size() != 0 || exp_q.size() != 0) begin
            g = (got_q.size() != 0) ? got_q.pop_front() : 'x;
            w = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
            n_vec++;
            if (g !== w) begin n_bad++; $display("FAIL hold_beat got %h want %h", g, w); end
        end
    endtask

    task automatic test_reset_mid();
        bit to;
        int gd;
        logic [31:0] g, w;
        for (int i = 0; i < 4; i++) src_q.push_back(32'hC0C0_0000 + 32'(i));
        repeat (5) tick();
        tile_k = 4;
        tile_beats = 0;
        n_done = 0;
        i_k_len = 8'd4;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        gd = 0;
        while (tile_beats < 2 && gd < 20) begin
            tick();
            gd++;
        end
        n_vec++;
        if (tile_beats !== 2) begin n_bad++; $display("FAIL mid_pre_beats got %0d want 2", tile_beats); end
        i_reset = 1'b1;
        tick();
        i_reset = 1'b0;
        n_vec++;
        if ({o_s_ready, o_data_valid, o_read_en, o_clear_acc, o_result_valid, o_busy, o_tile_done} !== 7'b1000000) begin
            n_bad++;
            $display("FAIL mid_reset_flags got %b want 1000000",
                {o_s_ready, o_data_valid, o_read_en, o_clear_acc, o_result_valid, o_busy, o_tile_done});
        end
        n_vec++;
        if ({o_b_vector, o_a_vector} !== 32'h0 || o_result !== 32'h0) begin
            n_bad++;
            $display("FAIL mid_reset_data got %h/%h want 0/0", {o_b_vector, o_a_vector}, o_result);
        end
        n_vec++;
        if (n_done !== 0) begin n_bad++; $display("FAIL mid_no_done got %0d want 0", n_done); end
        tile_k = 0;
        tile_beats = 0;
        rv_cnt = 0;
        held_valid = 1'b0;
        got_q.delete();
        exp_q.delete();
        src_q.push_back(32'h5555_AAAA);
        src_q.push_back(32'h3C3C_C3C3);
        run_tile(8'd2, 2, 40, 1'b0, to);
        n_vec++;
        if (to || tile_beats !== 2) begin n_bad++; $display("FAIL mid_fresh_beats got %0d want 2", tile_beats); end
        n_vec++;
        if (res_got !== cur_c) begin n_bad++; $display("FAIL mid_fresh_result got %h want %h", res_got, cur_c); end
        while (got_q.size() != 0 || exp_q.size() != 0) begin
            g = (got_q.size() != 0) ? got_q.pop_front() : 'x;
            w = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
            n_vec++;
            if (g !== w) begin n_bad++; $display("FAIL mid_fresh_beat got %h want %h", g, w); end
        end
    endtask

    initial begin
        i_reset = 1'b1;
        i_start = 1'b0;
        i_k_len = '0;
        i_s_a_vector = '0;
        i_s_b_vector = '0;
        i_s_valid = 1'b0;
        i_mac_done = 1'b0;
        i_ready_for_new = 1'b1;
        i_c_matrix = '0;
        i_result_ready = 1'b1;
        test_reset();
        test_basic();
        test_backpressure();
        test_fifo_full();
        test_k_zero();
        test_result_hold();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
